// File: rtl/dut_core.sv
`timescale 1ns/1ps
// dut_core: rotating arithmetic engine (16-bit reciprocal, 16/8 fixed-point
// divide, 16-bit rounded square root) working in place on a 256x8 memory.
// Build option: define DUT_ZERO_TRAP_EN so that zero operands bypass
// CALC/ROUND and go straight to STORE with the saturated/zero result.

module dat_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  // NOTE: the storage array has no reset; contents must survive every start pulse.
  logic [7:0] core [0:255];

  // Synchronous write port; the read port below is combinational.
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];
endmodule

module dut_core (
  input  logic clk,
  input  logic start,
  output logic done
);
  typedef enum logic [2:0] {S_RESET, S_LOAD, S_CALC, S_ROUND, S_STORE, S_DONE} state_t;

  localparam logic [1:0] OP_RECIP = 2'd0;
  localparam logic [1:0] OP_DIV   = 2'd1;
  localparam logic [1:0] OP_SQRT  = 2'd2;

`ifdef DUT_ZERO_TRAP_EN
  localparam bit ZeroTrap = 1'b1;
`else
  localparam bit ZeroTrap = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  sel = OP_RECIP;  // power-up value only; start never clears it
  logic [1:0]  op;              // operation latched for the current run
  logic [4:0]  cnt;             // byte / iteration counter within a phase
  logic [15:0] opnd;            // last two operand bytes loaded
  logic [24:0] dvd;             // dividend / radicand, consumed MSB first
  logic [24:0] quo;             // quotient with guard bit, or square root
  logic [15:0] rem;             // partial remainder
  logic [23:0] res;             // left-aligned result, shifted out during STORE

  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic        load_last, calc_last, store_last, is_sqrt, trap_now, zero_now;
  logic [7:0]  ld_base, st_base;
  logic [15:0] dsr;
  logic [23:0] opnd_nxt, sat_val, rnd_val;
  logic [16:0] div_trial;
  logic        div_ge;
  logic [15:0] div_rem;
  logic [10:0] sq_acc, sq_trial;
  logic        sq_ge;
  logic [8:0]  sq_rem;
  logic [7:0]  root_up;

  dat_mem dat_mem1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // A zero divisor/radicand: the divide operation only looks at its 8-bit divisor.
  function automatic logic is_zero(input logic [1:0] o, input logic [15:0] v);
    return (o == OP_DIV) ? (v[7:0] == 8'h00) : (v == 16'h0000);
  endfunction

  // Per-operation phase lengths, memory map and divisor selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    load_last  = 1'b0;
    calc_last  = 1'b0;
    store_last = 1'b0;
    ld_base    = 8'd13;
    st_base    = 8'd15;
    dsr        = opnd;
    sat_val    = 24'h000000;
    is_sqrt    = 1'b0;
    case (op)
      OP_RECIP: begin
        load_last  = (cnt == 5'd1);
        calc_last  = (cnt == 5'd16);
        store_last = (cnt == 5'd1);
        ld_base    = 8'd8;
        st_base    = 8'd10;
        sat_val    = 24'hFFFF00;
      end
      OP_DIV: begin
        load_last  = (cnt == 5'd2);
        calc_last  = (cnt == 5'd24);
        store_last = (cnt == 5'd2);
        ld_base    = 8'd0;
        st_base    = 8'd4;
        dsr        = {8'h00, opnd[7:0]};
        sat_val    = 24'hFFFFFF;
      end
      default: begin
        load_last  = (cnt == 5'd1);
        calc_last  = (cnt == 5'd7);
        store_last = (cnt == 5'd0);
        is_sqrt    = 1'b1;
      end
    endcase
  end

  // One iteration of the restoring divider and of the restoring square root,
  // plus the rounding/saturation applied in ROUND.
  always_comb begin
    opnd_nxt  = {opnd, mem_rdata};
    trap_now  = ZeroTrap && is_zero(op, opnd_nxt[15:0]);
    zero_now  = is_zero(op, opnd);
    div_trial = {rem, dvd[24]};
    div_ge    = (div_trial >= {1'b0, dsr});
    div_rem   = div_trial[15:0] - dsr;
    sq_acc    = {rem[8:0], dvd[24:23]};
    sq_trial  = {1'b0, quo[7:0], 2'b01};
    sq_ge     = (sq_acc >= sq_trial);
    sq_rem    = sq_acc[8:0] - sq_trial[8:0];
    // Remainder X - s*s above s means X > s*s + s: round the root up, capped at 8'hFF.
    root_up   = ((rem[8:0] > {1'b0, quo[7:0]}) && (quo[7:0] != 8'hFF)) ? quo[7:0] + 8'd1 : quo[7:0];
    case (op)
      OP_RECIP: rnd_val = {quo[16:1] + {15'd0, quo[0]}, 8'h00};
      OP_DIV:   rnd_val = quo[24:1] + {23'd0, quo[0]};
      default:  rnd_val = {root_up, 16'h0000};
    endcase
    if (zero_now) rnd_val = sat_val;
  end

  // State register with synchronous reset from start.
  always_ff @(posedge clk) begin
    if (start) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: state_d = S_LOAD;
        S_LOAD:  if (load_last) state_d = trap_now ? S_STORE : S_CALC;
        S_CALC:  if (calc_last) state_d = S_ROUND;
        S_ROUND: state_d = S_STORE;
        S_STORE: if (store_last) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_RESET;
      endcase
    end
  end

  // Outputs: done flag and the single memory port.
  always_comb begin
    done      = (state_q == S_DONE);
    mem_we    = (state_q == S_STORE);
    mem_addr  = (mem_we ? st_base : ld_base) + {3'b000, cnt};
    mem_wdata = res[23:16];
  end

  // Operation selector: latched into op and advanced when leaving RESET.
  always_ff @(posedge clk) begin
    if (!start && state_q == S_RESET) sel <= (sel == OP_SQRT) ? OP_RECIP : sel + 2'd1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (start) begin
      op   <= OP_RECIP;
      cnt  <= '0;
      opnd <= '0;
      dvd  <= '0;
      quo  <= '0;
      rem  <= '0;
      res  <= '0;
    end else begin
      case (state_q)
        S_RESET: begin
          op  <= sel;
          cnt <= '0;
        end
        S_LOAD: begin
          opnd <= opnd_nxt[15:0];
          if (load_last) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            case (op)
              OP_RECIP: dvd <= 25'h100_0000;              // 2^16 aligned for 17 steps
              OP_DIV:   dvd <= {opnd_nxt[23:8], 9'd0};    // N * 2^9
              default:  dvd <= {opnd_nxt[15:0], 9'd0};    // X, two bits per step
            endcase
            if (trap_now) res <= sat_val;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_CALC: begin
          cnt <= calc_last ? 5'd0 : cnt + 5'd1;
          if (is_sqrt) begin
            rem <= {7'd0, sq_ge ? sq_rem : sq_acc[8:0]};
            quo <= {quo[23:0], sq_ge};
            dvd <= {dvd[22:0], 2'b00};
          end else begin
            rem <= div_ge ? div_rem : div_trial[15:0];
            quo <= {quo[23:0], div_ge};
            dvd <= {dvd[23:0], 1'b0};
          end
        end
        S_ROUND: begin
          res <= rnd_val;
          cnt <= '0;
        end
        S_STORE: begin
          res <= {res[15:0], 8'h00};
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dut_core.sv
`timescale 1ns/1ps
// Self-checking bench for dut_core: table of plan vectors, random operands
// against a behavioural model, and hand-written abort / long-start sequences.
module tb_dut_core;
  logic clk = 1'b0;
  logic start;
  logic done;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem_model [0:255];

`ifdef DUT_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dut_core dut (.clk(clk), .start(start), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [15:0] a;    // D, N or X
    logic [7:0]  b;    // d (divide only)
    logic [23:0] exp;  // right-aligned result
  } vec_t;

  vec_t vecs [15];

  // Behavioural model: the arithmetic definitions, computed directly.
  function automatic logic [23:0] ref_result(input int op, input logic [15:0] a, input logic [7:0] b);
    longint q;
    int s, x;
    case (op)
      0: begin
        if (a == 16'd0) return 24'h00FFFF;
        q = 65536 / longint'(a);
        return 24'((q + 1) / 2);
      end
      1: begin
        if (b == 8'd0) return 24'hFFFFFF;
        q = (longint'(a) * 512) / longint'(b);
        return 24'((q + 1) / 2);
      end
      default: begin
        x = int'(a);
        s = 0;
        while ((s + 1) * (s + 1) <= x) s++;
        if (x > s * s + s) s++;
        if (s > 255) s = 255;
        return 24'(s);
      end
    endcase
  endfunction

  function automatic int exp_latency(input int op, input bit zero);
    if (TRAP && zero) return (op == 0) ? 4 : (op == 1) ? 6 : 3;
    return (op == 0) ? 22 : (op == 1) ? 32 : 12;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_mem(input int addr, input logic [7:0] val);
    dut.dat_mem1.core[addr] = val;
    mem_model[addr] = val;
  endtask

  task automatic write_operands(input int op, input logic [15:0] a, input logic [7:0] b);
    case (op)
      0: begin write_mem(8, a[15:8]);  write_mem(9, a[7:0]); end
      1: begin write_mem(0, a[15:8]);  write_mem(1, a[7:0]); write_mem(2, b); end
      default: begin write_mem(13, a[15:8]); write_mem(14, a[7:0]); end
    endcase
  endtask

  // Raise start, preload operands while it is high, drop it after hi cycles.
  task automatic launch(input int op, input logic [15:0] a, input logic [7:0] b, input int hi);
    start = 1'b1;
    write_operands(op, a, b);
    repeat (hi) @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, result bytes, the rest of
  // memory and that done stays high.
  task automatic finish_op(input int op, input logic [15:0] a, input logic [7:0] b,
                           input logic [23:0] exp, input string name);
    logic [23:0] got;
    int n, lat, bad;
    bit zero;
    zero = (op == 1) ? (b == 8'd0) : (a == 16'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 64);
    lat = done ? n - 1 : -1;
    check({name, "_lat"}, lat, exp_latency(op, zero));
    case (op)
      0: begin
        got = {8'h00, dut.dat_mem1.core[10], dut.dat_mem1.core[11]};
        mem_model[10] = exp[15:8];
        mem_model[11] = exp[7:0];
      end
      1: begin
        got = {dut.dat_mem1.core[4], dut.dat_mem1.core[5], dut.dat_mem1.core[6]};
        mem_model[4] = exp[23:16];
        mem_model[5] = exp[15:8];
        mem_model[6] = exp[7:0];
      end
      default: begin
        got = {16'h0000, dut.dat_mem1.core[15]};
        mem_model[15] = exp[7:0];
      end
    endcase
    check({name, "_res"}, {8'h00, got}, {8'h00, exp});
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.dat_mem1.core[i] !== mem_model[i]) bad++;
    check({name, "_mem"}, bad, 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_hold"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Plan vectors in rotation order 0,1,2,...
    vecs[0]  = '{0, 16'h0003, 8'h00, 24'h002AAB};
    vecs[1]  = '{1, 16'h0001, 8'h03, 24'h000055};
    vecs[2]  = '{2, 16'hFFFF, 8'h00, 24'h0000FF};
    vecs[3]  = '{0, 16'h0001, 8'h00, 24'h008000};
    vecs[4]  = '{1, 16'hFFFF, 8'h01, 24'hFFFF00};
    vecs[5]  = '{2, 16'h0002, 8'h00, 24'h000001};
    vecs[6]  = '{0, 16'h0000, 8'h00, 24'h00FFFF};
    vecs[7]  = '{1, 16'h1234, 8'h00, 24'hFFFFFF};
    vecs[8]  = '{2, 16'h0003, 8'h00, 24'h000002};
    vecs[9]  = '{0, 16'h00FF, 8'h00, 24'h000081};
    vecs[10] = '{1, 16'h1000, 8'h80, 24'h002000};
    vecs[11] = '{2, 16'h0000, 8'h00, 24'h000000};
    vecs[12] = '{0, 16'hFFFF, 8'h00, 24'h000001};
    vecs[13] = '{1, 16'h0064, 8'h07, 24'h000E49};
    vecs[14] = '{2, 16'h0038, 8'h00, 24'h000007};

    start = 1'b1;
    for (int i = 0; i < 256; i++) write_mem(i, 8'($urandom));
    repeat (4) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 2);
      finish_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("tab%0d", i));
    end

    // Random operands; zero operands appear now and then.
    for (int i = 0; i < 12; i++) begin
      int op;
      logic [15:0] a;
      logic [7:0] b;
      op = i % 3;
      a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      launch(op, a, b, 2);
      finish_op(op, a, b, ref_result(op, a, b), $sformatf("rnd%0d", i));
    end

    // start held high for many cycles: a single launch of Op0.
    launch(0, 16'h0005, 8'h00, 10);
    finish_op(0, 16'h0005, 8'h00, ref_result(0, 16'h0005, 8'h00), "long_start");

    // Abort Op1 five cycles in; the following falling edge runs Op2.
    launch(1, 16'h1234, 8'h56, 2);
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy", {31'd0, done}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    write_operands(2, 16'd200, 8'h00);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    finish_op(2, 16'd200, 8'h00, 24'h00000E, "abort_next");

    // Rotation wraps back to Op0 after the aborted sequence.
    launch(0, 16'h0000, 8'h00, 2);
    finish_op(0, 16'h0000, 8'h00, ref_result(0, 16'h0000, 8'h00), "wrap_zero");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dut_core.md
# dut_core

Fixed-function arithmetic engine with an embedded 256×8 data memory. It runs three operations in a fixed rotating order: a 16-bit reciprocal, a 16÷8 fixed-point divide and a 16-bit rounded square root. Each operation is launched by a `start` pulse. The engine reads its operands from, and writes its results to, fixed memory addresses. A host or bench preloads the operands directly into the memory array before releasing `start`, and reads the results back after `done`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `start`  in  1  synchronous, active-high reset and launch.
  - While high, the engine is held in reset.
  - The falling edge launches the next operation.
- `done`  out  1  high when the current operation's results are stored; held high until `start` rises.
- Memory: submodule instance `dat_mem1` with array `core[0:255]`, 8 bits per entry.
  - Asynchronous read, synchronous write.
  - `core` is never cleared by `start`; contents persist across operations.

## Operation
- Operation selector `sel` is a 2-bit register.
  - Power-up value 0; `start` does not affect it.
  - Advances on the `start` falling edge, after latching the operation to run.
  - Sequence 0→1→2→0.
- Big-endian operand and result layout:
  - **Op0, reciprocal:** D = {core[8],core[9]}. R1 = (floor(2^16/D)+1)>>1, 16 bits. D=0 → 16'hFFFF. Writes core[10]=R1[15:8], core[11]=R1[7:0].
  - **Op1, divide:** N = {core[0],core[1]}, d = core[2]. R2 = (floor(N·2^9/d)+1)>>1, 24 bits (max 24'hFFFF00, no overflow). d=0 → 24'hFFFFFF. Writes core[4],core[5],core[6] (MSB first).
  - **Op2, square root:** X = {core[13],core[14]}.
    - Let s = floor(sqrt(X)). R3 = s+1 if X > s²+s, else s.
    - R3 is saturated to 8'hFF, so X ≥ 65281 gives 8'hFF.
    - X=0 → 0.
    - Writes core[15].
- Datapath:
  - One 25-bit restoring shift-subtract divider serves Op0 and Op1. It produces the quotient plus one guard bit; the final step adds the guard bit and shifts right.
  - Op2 uses a bit-serial restoring square root of 8 iterations, followed by the s²+s comparison.
  - Op0 with D=0 is saturated explicitly.
- FSM: RESET → LOAD → CALC → ROUND → STORE → DONE.
  - RESET is entered whenever `start`=1.
  - LOAD reads one operand byte per cycle.
  - STORE writes one result byte per cycle, most significant byte first.
  - DONE holds until `start`.
- No memory locations other than the result bytes are written.

## Timing
- Reset state: `done`=0, FSM in RESET, working registers 0.
- Latency is measured from the first clock with `start`=0 to `done`=1:
  - Op0: 2 load + 17 calc + 1 round + 2 store = 22 cycles.
  - Op1: 3 load + 25 calc + 1 round + 3 store = 32 cycles.
  - Op2: 2 load + 8 calc + 1 round + 1 store = 12 cycles.
- `done` rises in the cycle after the last result write.
- `start` reasserted mid-operation: the engine aborts in the next cycle and `done`=0.
  - Result bytes may be partially written.
  - `sel` has already advanced, so the aborted operation is skipped.
- `start` held high for many cycles: stays in RESET; only one falling edge counts.
- Operands written to memory while `start`=1 are guaranteed visible at LOAD.

## Configuration
- `DUT_ZERO_TRAP_EN`
  - Defined: a zero operand (D=0, d=0 or X=0) detected at the end of LOAD skips CALC and ROUND and goes straight to STORE with the saturated or zero result. Zero-operand latency becomes Op0 4, Op1 6, Op2 3 cycles.
  - Undefined: zero operands take the full datapath. The same results are required via the explicit saturation in ROUND, with normal latency.

## Test plan
- Op0, D=16'h0003 → core[10..11] = 8'h2A, 8'hAB in 22 cycles; D=1 → 8'h80, 8'h00; D=0 → 8'hFF, 8'hFF.
- Op1:
  - N=16'h0001, d=8'h03 → core[4..6] = 00 00 55.
  - N=16'hFFFF, d=8'h01 → FF FF 00.
  - d=0 → FF FF FF.
- Op2:
  - X=65535 → core[15]=8'hFF.
  - X=2 → 8'h01.
  - X=3 → 8'h02.
  - X=0 → 8'h00.
  - X=56 → 8'h07.
- Three consecutive `start` pulses (2 cycles high each) run Op0, Op1, Op2 in order; a fourth pulse runs Op0 again.
- Raise `start` 5 cycles into Op1 → `done`=0 next cycle; the next pulse runs Op2.
- With and without `DUT_ZERO_TRAP_EN`, zero operands give identical results; measure both latencies.
